// File: rtl/aging_warning_gen.sv
// Aging-sensor warning generator: counts main/shadow capture mismatches per window and pulses on threshold.
// Optional build macro AGING_WARN_MASK_EN adds a path_mask input that excludes selected bits from the compare.
module aging_warning_gen #(
    parameter int WIDTH   = 8,
    parameter int WINDOW  = 16,
    parameter int THRESH  = 2,
    parameter int HOLDOFF = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         sample_valid,
    input  logic [WIDTH-1:0]             data_main,
    input  logic [WIDTH-1:0]             data_shadow,
`ifdef AGING_WARN_MASK_EN
    input  logic [WIDTH-1:0]             path_mask,
`endif
    input  logic                         flag_clr,
    output logic                         warning_signal,
    output logic                         warn_flag,
    output logic [$clog2(THRESH+1)-1:0]  err_cnt,
    output logic                         busy
);

    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(THRESH + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_FIRE  = EW'(THRESH - 1);
    localparam logic [EW-1:0] ERR_MAX   = EW'(THRESH);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WINDOW  = 2'd1,
        S_FIRE    = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   win_cnt_q, win_cnt_d;
    logic [EW-1:0]   err_cnt_q, err_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            mismatch_q, mismatch_d;
    logic            warning_q, warning_d;
    logic            warn_flag_q, warn_flag_d;
    logic            busy_q, busy_d;
    logic [WIDTH-1:0] diff_s;

    // Bitwise difference between main and shadow captures, optionally masked.
    always_comb begin
`ifdef AGING_WARN_MASK_EN
        diff_s = (data_main ^ data_shadow) & ~path_mask;
`else
        diff_s = data_main ^ data_shadow;
`endif
    end

    // Next-state, counter and compare-stage logic; enable low overrides everything.
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        err_cnt_d  = err_cnt_q;
        hold_cnt_d = hold_cnt_q;
        mismatch_d = sample_valid & (|diff_s);
        if (!enable) begin
            state_d    = S_IDLE;
            win_cnt_d  = '0;
            err_cnt_d  = '0;
            hold_cnt_d = '0;
            mismatch_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d    = S_WINDOW;
                    win_cnt_d  = '0;
                    err_cnt_d  = '0;
                    hold_cnt_d = '0;
                end
                S_WINDOW: begin
                    if (mismatch_q && (err_cnt_q == ERR_FIRE)) begin
                        // Reaching the threshold wins over a simultaneous window end.
                        state_d   = S_FIRE;
                        err_cnt_d = ERR_MAX;
                        win_cnt_d = '0;
                    end else begin
                        if (mismatch_q) begin
                            err_cnt_d = err_cnt_q + EW'(1);
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        if (win_cnt_q == WIN_LAST) begin
                            win_cnt_d = '0;
                            err_cnt_d = '0;
                        end else begin
                            win_cnt_d = win_cnt_q + WW'(1);
                        end
                    end
                end
                S_FIRE: begin
                    err_cnt_d  = '0;
                    win_cnt_d  = '0;
                    hold_cnt_d = '0;
                    if (HOLDOFF > 0) begin
                        state_d = S_HOLDOFF;
                    end else begin
                        state_d = S_WINDOW;
                    end
                end
                S_HOLDOFF: begin
                    err_cnt_d = '0;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = S_WINDOW;
                        win_cnt_d  = '0;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    win_cnt_d  = '0;
                    err_cnt_d  = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Registered outputs decoded from the next state; a coincident set beats flag_clr.
    always_comb begin
        warning_d = (state_d == S_FIRE);
        busy_d    = (state_d != S_IDLE);
        if (state_d == S_FIRE) begin
            warn_flag_d = 1'b1;
        end else if (flag_clr) begin
            warn_flag_d = 1'b0;
        end else begin
            warn_flag_d = warn_flag_q;
        end
    end

    // State, counters and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            win_cnt_q   <= '0;
            err_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            mismatch_q  <= 1'b0;
            warning_q   <= 1'b0;
            warn_flag_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            err_cnt_q   <= err_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            mismatch_q  <= mismatch_d;
            warning_q   <= warning_d;
            warn_flag_q <= warn_flag_d;
            busy_q      <= busy_d;
        end
    end

    assign warning_signal = warning_q;
    assign warn_flag      = warn_flag_q;
    assign err_cnt        = err_cnt_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_aging_warning_gen.sv
// Directed testbench for aging_warning_gen (default parameters); status = {warning, flag, busy, err_cnt}.
module tb_aging_warning_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       sample_valid;
    logic [7:0] data_main;
    logic [7:0] data_shadow;
`ifdef AGING_WARN_MASK_EN
    logic [7:0] path_mask;
`endif
    logic       flag_clr;
    logic       warning_signal;
    logic       warn_flag;
    logic [1:0] err_cnt;
    logic       busy;
    logic [4:0] st;

    int checks = 0;
    int errors = 0;

    assign st = {warning_signal, warn_flag, busy, err_cnt};

    always #5 clk = ~clk;

    aging_warning_gen dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .sample_valid   (sample_valid),
        .data_main      (data_main),
        .data_shadow    (data_shadow),
`ifdef AGING_WARN_MASK_EN
        .path_mask      (path_mask),
`endif
        .flag_clr       (flag_clr),
        .warning_signal (warning_signal),
        .warn_flag      (warn_flag),
        .err_cnt        (err_cnt),
        .busy           (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [7:0] m, input logic [7:0] s);
        sample_valid = sv;
        data_main    = m;
        data_shadow  = s;
    endtask

    task automatic do_reset;
        reset    = 1'b0;
        enable   = 1'b0;
        flag_clr = 1'b0;
`ifdef AGING_WARN_MASK_EN
        path_mask = 8'h00;
`endif
        drive(1'b0, 8'h00, 8'h00);
        #12;
        reset = 1'b1;
        tick();
    endtask

    // Enable from IDLE: one edge later the window starts at win_cnt 0.
    task automatic start;
        enable = 1'b1;
        tick();
    endtask

    // Two consecutive mismatches from window start; leaves the DUT in FIRE.
    task automatic fire_seq;
        drive(1'b1, 8'hC3, 8'hC2);
        tick();
        drive(1'b1, 8'h10, 8'h30);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0;
        enable = 1'b1;
        flag_clr = 1'b0;
        drive(1'b1, 8'hFF, 8'h00);
        #3;
        checks++;
        if (st !== 5'b0) begin errors++; $display("FAIL reset_async status=%b exp=%b", st, 5'b0); end
        do_reset();
        checks++;
        if (st !== 5'b0) begin errors++; $display("FAIL reset_idle status=%b exp=%b", st, 5'b0); end
    endtask

    task automatic test_threshold;
        do_reset();
        start();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL thr_start status=%b", st); end
        tick();
        drive(1'b0, 8'hFF, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL thr_invalid_ignored status=%b exp=00100", st); end
        drive(1'b1, 8'h5A, 8'h5B);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd1}) begin errors++; $display("FAIL thr_err1 status=%b exp=00101", st); end
        drive(1'b1, 8'h80, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd1}) begin errors++; $display("FAIL thr_pre_fire status=%b exp=00101", st); end
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b1, 1'b1, 1'b1, 2'd2}) begin errors++; $display("FAIL thr_fire status=%b exp=11110", st); end
        tick();
        checks++;
        if (st !== {1'b0, 1'b1, 1'b1, 2'd0}) begin errors++; $display("FAIL thr_pulse_end status=%b exp=01100", st); end
        for (int i = 0; i < 8; i++) begin
            if (i < 6) drive(1'b1, 8'hFF, 8'h00);
            else drive(1'b0, 8'h00, 8'h00);
            tick();
            checks++;
            if (st !== {1'b0, 1'b1, 1'b1, 2'd0}) begin errors++; $display("FAIL thr_holdoff_%0d status=%b exp=01100", i, st); end
        end
        drive(1'b1, 8'h01, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b1, 1'b1, 2'd1}) begin errors++; $display("FAIL thr_after_holdoff status=%b exp=01101", st); end
        enable = 1'b0;
        tick();
        checks++;
        if (st !== {1'b0, 1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL thr_disable status=%b exp=01000", st); end
    endtask

    task automatic test_window_expiry;
        do_reset();
        start();
        tick();
        drive(1'b1, 8'h0F, 8'h0E);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd1}) begin errors++; $display("FAIL exp_err1 status=%b exp=00101", st); end
        repeat (12) tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd1}) begin errors++; $display("FAIL exp_last_cycle status=%b exp=00101", st); end
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL exp_boundary status=%b exp=00100", st); end
        drive(1'b1, 8'h44, 8'h40);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd1}) begin errors++; $display("FAIL exp_next_window status=%b exp=00101", st); end
        repeat (14) tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL exp_second_boundary status=%b exp=00100", st); end
        repeat (14) tick();
        drive(1'b1, 8'hAA, 8'h55);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL exp_last_dropped status=%b exp=00100", st); end
    endtask

    task automatic test_last_cycle_fire;
        do_reset();
        start();
        repeat (3) tick();
        drive(1'b1, 8'h01, 8'h03);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd1}) begin errors++; $display("FAIL last_err1 status=%b exp=00101", st); end
        repeat (9) tick();
        drive(1'b1, 8'h77, 8'hF7);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b1, 1'b1, 1'b1, 2'd2}) begin errors++; $display("FAIL last_fire status=%b exp=11110", st); end
        tick();
        checks++;
        if (st !== {1'b0, 1'b1, 1'b1, 2'd0}) begin errors++; $display("FAIL last_pulse_end status=%b exp=01100", st); end
    endtask

    task automatic test_enable_drop;
        do_reset();
        start();
        fire_seq();
        checks++;
        if (st !== {1'b1, 1'b1, 1'b1, 2'd2}) begin errors++; $display("FAIL en_first_fire status=%b exp=11110", st); end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        drive(1'b1, 8'h09, 8'h08);
        tick();
        drive(1'b1, 8'h90, 8'h80);
        tick();
        checks++;
        if (st !== {1'b0, 1'b1, 1'b1, 2'd1}) begin errors++; $display("FAIL en_armed status=%b exp=01101", st); end
        enable = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL en_abort status=%b exp=01000", st); end
        tick();
        checks++;
        if (st !== {1'b0, 1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL en_idle_hold status=%b exp=01000", st); end
    endtask

    task automatic test_flag_clr;
        do_reset();
        start();
        fire_seq();
        flag_clr = 1'b1;
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL flag_clear status=%b exp=00100", st); end
        flag_clr = 1'b0;
        repeat (8) tick();
        drive(1'b1, 8'h21, 8'h20);
        tick();
        drive(1'b1, 8'h21, 8'h23);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        flag_clr = 1'b1;
        tick();
        checks++;
        if (st !== {1'b1, 1'b1, 1'b1, 2'd2}) begin errors++; $display("FAIL flag_set_wins status=%b exp=11110", st); end
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL flag_clear_again status=%b exp=00100", st); end
        flag_clr = 1'b0;
    endtask

    task automatic test_reset_holdoff;
        do_reset();
        start();
        fire_seq();
        tick();
        tick();
        reset = 1'b0;
        #2;
        checks++;
        if (st !== 5'b0) begin errors++; $display("FAIL rst_hold_async status=%b exp=00000", st); end
        tick();
        checks++;
        if (st !== 5'b0) begin errors++; $display("FAIL rst_hold_held status=%b exp=00000", st); end
        reset = 1'b1;
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL rst_hold_restart status=%b exp=00100", st); end
    endtask

`ifdef AGING_WARN_MASK_EN
    task automatic test_mask;
        do_reset();
        path_mask = 8'h01;
        start();
        drive(1'b1, 8'h01, 8'h00);
        tick();
        drive(1'b1, 8'h11, 8'h10);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL mask_ignored status=%b exp=00100", st); end
        drive(1'b1, 8'h02, 8'h00);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        checks++;
        if (st !== {1'b0, 1'b0, 1'b1, 2'd1}) begin errors++; $display("FAIL mask_counted status=%b exp=00101", st); end
    endtask
`endif

    initial begin
        test_reset();
        test_threshold();
        test_window_expiry();
        test_last_cycle_fire();
        test_enable_drop();
        test_flag_clr();
        test_reset_holdoff();
`ifdef AGING_WARN_MASK_EN
        test_mask();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aging_warning_gen.md
Name: aging_warning_gen

Overview:
- Upstream stage of the aging-sensor warning counter. Compares main-flop and shadow-flop (delayed-clock) captures of monitored critical paths.
- Counts mismatches inside a fixed evaluation window. Emits a single-cycle warning_signal pulse when the count reaches a threshold, then holds off.
- warning_signal drives the downstream counter's increment input directly, one pulse per detected aging event.

Parameters:
- WIDTH, 8, number of monitored path bits in data_main/data_shadow.
- WINDOW, 16, evaluation window length in clock cycles (>=2).
- THRESH, 2, mismatch count within one window that triggers a warning (1..WINDOW).
- HOLDOFF, 8, cycles after a warning during which mismatches are ignored (0 allowed).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  monitoring enable; low forces IDLE.
- sample_valid  input  1  data_main/data_shadow are valid this cycle.
- data_main  input  WIDTH  main-flop capture of monitored paths.
- data_shadow  input  WIDTH  shadow-flop capture of same paths.
- flag_clr  input  1  clears sticky warn_flag.
- warning_signal  output  1  one-cycle warning pulse (registered).
- warn_flag  output  1  sticky: a warning has fired since last clear.
- err_cnt  output  $clog2(THRESH+1)  current-window mismatch count.
- busy  output  1  high in WINDOW, FIRE, HOLDOFF.

Behaviour:
- Reset: reset is asynchronous, active-low; clock is clk. While reset=0: state=IDLE, all counters 0, mismatch_q=0, warning_signal=0, warn_flag=0, err_cnt=0, busy=0.
- Compare stage: on each edge, mismatch_q <= sample_valid & |(data_main ^ data_shadow). This register is cleared whenever enable=0.
- States: IDLE, WINDOW, FIRE, HOLDOFF. State register and all outputs are registered.
- Any state with enable=0 → IDLE next edge. win_cnt, err_cnt, hold_cnt and mismatch_q clear; warning_signal=0 (a pending FIRE is aborted). enable has priority over every other transition.
- IDLE, enable=1 → WINDOW with win_cnt=0, err_cnt=0.
- WINDOW, per edge:
  - If mismatch_q=1 and err_cnt==THRESH-1 → FIRE; err_cnt <= THRESH. This has priority over window end.
  - Else if mismatch_q=1 → err_cnt+1.
  - If win_cnt==WINDOW-1 without firing → win_cnt=0, err_cnt=0, stay in WINDOW (back-to-back windows, no gap). A mismatch on that last cycle that does not reach THRESH is dropped, not carried over.
  - Otherwise win_cnt+1.
- FIRE: lasts exactly one cycle. warning_signal=1 only in this state. warn_flag is set at entry.
  - HOLDOFF>0 → HOLDOFF with hold_cnt=0.
  - HOLDOFF==0 → WINDOW with counters cleared.
- HOLDOFF: mismatch_q is ignored; err_cnt is held at 0. hold_cnt increments. At hold_cnt==HOLDOFF-1 → WINDOW with win_cnt=0, err_cnt=0.
- Latency: a mismatch presented with sample_valid at edge k (registered at k) and reaching THRESH → FIRE at edge k+1. warning_signal is high from k+1 to k+2.
- warn_flag: set on entry to FIRE, cleared by flag_clr. If set and clear occur on the same edge, set wins. It is not cleared by enable=0.
- err_cnt saturates at THRESH and never wraps. All counters are sized via $clog2 with no overflow possible.
- Minimum spacing between warning_signal pulses: 1+HOLDOFF+THRESH cycles.

Optional Feature:
- Macro AGING_WARN_MASK_EN.
- Defined: adds input port path_mask (WIDTH bits, after data_shadow). Compare becomes |((data_main ^ data_shadow) & ~path_mask); a masked bit never causes a mismatch. path_mask is sampled with the data on the same edge.
- Undefined: port absent; all WIDTH bits are compared.

Test Plan:
- Reset mid-HOLDOFF: assert reset=0 for 1 cycle during HOLDOFF → all outputs 0 and state IDLE immediately. After release with enable=1 → busy=1 at the next edge.
- Threshold hit: defaults, enable=1, mismatch with sample_valid on window cycles 3 and 5 → err_cnt 1 then 2. warning_signal high for exactly 1 cycle, 2 cycles after the second mismatch. warn_flag=1, then 8 HOLDOFF cycles with mismatches ignored.
- Window expiry: 1 mismatch at cycle 2, none until cycle 15 → err_cnt returns to 0 at the window boundary, no warning. Second mismatch at next-window cycle 1 → err_cnt=1, no warning.
- Last-cycle fire: mismatch at win_cnt=4 and at win_cnt=15 → FIRE takes priority over window restart; warning pulse issued.
- enable drop: enable=0 in the same cycle FIRE would be entered → no pulse, state IDLE, err_cnt=0. warn_flag unchanged.
- Flag and mask: flag_clr with no FIRE → warn_flag clears. flag_clr coincident with FIRE entry → warn_flag stays 1. With AGING_WARN_MASK_EN and path_mask=8'h01, data_main^data_shadow=8'h01 → no mismatch counted; 8'h02 → counted.
